// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with per-register busy scoreboard.
// Ports: iClk/iRst (async active-low); NUM_RD read ports (iRdEn, iRdAddr,
//   oRdData, oRdBusy); NUM_WR write ports (iWrEn, iWrAddr, iWrData);
//   reservation request (iRsvEn, iRsvAddr); oReady once all registers are zeroed.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic [NUM_RD-1:0]              iRdEn,
    input  logic [NUM_RD-1:0][AW-1:0]      iRdAddr,
    output logic [NUM_RD-1:0][XLEN-1:0]    oRdData,
    output logic [NUM_RD-1:0]              oRdBusy,
    input  logic [NUM_WR-1:0]              iWrEn,
    input  logic [NUM_WR-1:0][AW-1:0]      iWrAddr,
    input  logic [NUM_WR-1:0][XLEN-1:0]    iWrData,
    input  logic                           iRsvEn,
    input  logic [AW-1:0]                  iRsvAddr,
    output logic                           oReady
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [REG_NUM-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]     regs_q [REG_NUM];
    logic                run;

    assign run    = (state_q == ST_RUN);
    assign oReady = run;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(REG_NUM - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Reservation is applied after the write clears so that a new producer
    // issued in the same cycle keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (iWrEn[w]) begin
                    busy_d[iWrAddr[w]] = 1'b0;
                end
            end
            if (iRsvEn) begin
                busy_d[iRsvAddr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Storage has no reset; INIT sweeps zeros through it instead.
    // Later ports overwrite earlier ones, giving the highest index priority.
    always_ff @(posedge iClk) begin
        if (!run) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (iWrEn[w] && (iWrAddr[w] != '0)) begin
                    regs_q[iWrAddr[w]] <= iWrData[w];
                end
            end
        end
    end

    always_comb begin
        logic            hit;
        logic [XLEN-1:0] byp;
        oRdData = '0;
        oRdBusy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            hit = 1'b0;
            byp = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (iWrEn[w] && (iWrAddr[w] != '0) &&
                    (iWrAddr[w] == iRdAddr[r])) begin
                    hit = 1'b1;
                    byp = iWrData[w];
                end
            end
            if (BYPASS == 0) begin
                hit = 1'b0;
            end
            // Outputs stay zero during reset/INIT, hiding uninitialised storage.
            if (run && iRdEn[r]) begin
                if (iRdAddr[r] != '0) begin
                    oRdData[r] = hit ? byp : regs_q[iRdAddr[r]];
                end
                oRdBusy[r] = busy_q[iRdAddr[r]] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with an expectation queue.
// Two instances: forwarding with two write ports, and no forwarding.
module tb_regfile_mp;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        rd_en;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][31:0]  wr_data;
    logic              rsv_en;
    logic [4:0]        rsv_addr;
    logic              ready;
    logic [1:0][31:0]  nb_data;
    logic [1:0]        nb_busy;
    logic              nb_ready;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .REG_NUM(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut (
        .iClk(clk), .iRst(rst_n),
        .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(rd_data), .oRdBusy(rd_busy),
        .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data),
        .iRsvEn(rsv_en), .iRsvAddr(rsv_addr), .oReady(ready)
    );

    regfile_mp #(.XLEN(32), .REG_NUM(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) u_nb (
        .iClk(clk), .iRst(rst_n),
        .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(nb_data), .oRdBusy(nb_busy),
        .iWrEn(wr_en[0:0]), .iWrAddr(wr_addr[0:0]), .iWrData(wr_data[0:0]),
        .iRsvEn(rsv_en), .iRsvAddr(rsv_addr), .oReady(nb_ready)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s no expectation queued, observed=%h", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val && tag == e.tag) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (queued %s)", tag, obs, e.val, e.tag);
        end
    endtask

    task automatic step();
        @(negedge clk);
        wr_en  = '0;
        rsv_en = 1'b0;
        rd_en  = 2'b11;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_en    = 2'b11;
        rd_addr  = '0;
        rd_addr[0] = 5'd5;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;

        repeat (3) @(negedge clk);
        #2;
        push("rst_ready", 0); push("rst_rd0", 0);
        push("rst_busy", 0);  push("nb_rst_rd0", 0);
        pop_chk("rst_ready", 32'(ready));
        pop_chk("rst_rd0", rd_data[0]);
        pop_chk("rst_busy", 32'(rd_busy));
        pop_chk("nb_rst_rd0", nb_data[0]);

        // INIT with writes and reservations to x6 that must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr[0] = 5'd6; rd_addr[1] = 5'd6;
        wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 32) begin
                wr_en = '0; rsv_en = 1'b0;
            end
            #2;
            push("init_ready", (k == 32) ? 32'd1 : 32'd0);
            pop_chk("init_ready", 32'(ready));
            if (k < 32) begin
                push("init_rd0", 0); push("init_busy", 0);
                pop_chk("init_rd0", rd_data[0]);
                pop_chk("init_busy", 32'(rd_busy));
            end
        end

        step(); rd_addr[0] = 5'd6; rd_addr[1] = 5'd6; #2;
        push("x6_after_init", 0); push("x6_busy", 0);
        pop_chk("x6_after_init", rd_data[0]);
        pop_chk("x6_busy", 32'(rd_busy));

        for (int r = 0; r < 32; r++) begin
            step(); rd_addr[0] = 5'(r); rd_addr[1] = 5'(31 - r); #2;
            push("zero_p0", 0); push("zero_p1", 0);
            pop_chk("zero_p0", rd_data[0]);
            pop_chk("zero_p1", rd_data[1]);
        end

        step(); wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
        rd_addr[0] = 5'd1; rd_addr[1] = 5'd1;
        step(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd5; #2;
        push("x5_p0", 32'hDEAD_BEEF); push("x5_p1", 32'hDEAD_BEEF);
        push("nb_x5", 32'hDEAD_BEEF);
        pop_chk("x5_p0", rd_data[0]);
        pop_chk("x5_p1", rd_data[1]);
        pop_chk("nb_x5", nb_data[0]);

        step(); wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234;
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd0; #2;
        push("x0_byp", 0); pop_chk("x0_byp", rd_data[0]);
        step(); rd_addr[0] = 5'd0; rd_addr[1] = 5'd0; #2;
        push("x0_p0", 0); push("x0_p1", 0);
        pop_chk("x0_p0", rd_data[0]);
        pop_chk("x0_p1", rd_data[1]);

        step(); rsv_en = 1'b1; rsv_addr = 5'd7;
        step(); wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'hA5A5_A5A5;
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd7; #2;
        push("byp_p0", 32'hA5A5_A5A5); push("byp_p1", 32'hA5A5_A5A5);
        push("byp_busy", 0); push("nb_old", 0); push("nb_busy", 1);
        pop_chk("byp_p0", rd_data[0]);
        pop_chk("byp_p1", rd_data[1]);
        pop_chk("byp_busy", 32'(rd_busy));
        pop_chk("nb_old", nb_data[0]);
        pop_chk("nb_busy", 32'(nb_busy[0]));
        step(); rd_addr[0] = 5'd7; rd_addr[1] = 5'd7; #2;
        push("x7", 32'hA5A5_A5A5); push("nb_x7", 32'hA5A5_A5A5);
        push("x7_busy", 0); push("nb_x7_busy", 0);
        pop_chk("x7", rd_data[0]);
        pop_chk("nb_x7", nb_data[0]);
        pop_chk("x7_busy", 32'(rd_busy));
        pop_chk("nb_x7_busy", 32'(nb_busy));

        step(); wr_en = 2'b11;
        wr_addr[0] = 5'd3; wr_data[0] = 32'h11;
        wr_addr[1] = 5'd3; wr_data[1] = 32'h22;
        rd_addr[0] = 5'd3; rd_addr[1] = 5'd3; #2;
        push("dual_byp", 32'h22); push("nb_dual_old", 0);
        pop_chk("dual_byp", rd_data[0]);
        pop_chk("nb_dual_old", nb_data[0]);
        step(); rd_addr[0] = 5'd3; rd_addr[1] = 5'd3; #2;
        push("x3", 32'h22); push("nb_x3", 32'h11);
        pop_chk("x3", rd_data[1]);
        pop_chk("nb_x3", nb_data[1]);

        step(); rsv_en = 1'b1; rsv_addr = 5'd9;
        step(); rd_en = 2'b01; rd_addr[0] = 5'd9; rd_addr[1] = 5'd9; #2;
        push("rsv_busy", 32'b01); push("rden0_data", 0);
        pop_chk("rsv_busy", 32'(rd_busy));
        pop_chk("rden0_data", rd_data[1]);
        step(); wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
        step(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd9; #2;
        push("wr_clr_busy", 0); push("x9", 32'h99);
        pop_chk("wr_clr_busy", 32'(rd_busy));
        pop_chk("x9", rd_data[0]);
        step(); rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h55;
        step(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd9; #2;
        push("rsv_wr_busy", 32'b11); push("x9_new", 32'h55);
        push("nb_rsv_busy", 1); push("nb_x9", 32'h99);
        pop_chk("rsv_wr_busy", 32'(rd_busy));
        pop_chk("x9_new", rd_data[1]);
        pop_chk("nb_rsv_busy", 32'(nb_busy[0]));
        pop_chk("nb_x9", nb_data[0]);
        step(); rsv_en = 1'b1; rsv_addr = 5'd0;
        step(); rd_addr[0] = 5'd0; rd_addr[1] = 5'd0; #2;
        push("x0_busy", 0); pop_chk("x0_busy", 32'(rd_busy));

        // asynchronous reset while x9 is busy
        step(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd9;
        rst_n = 1'b0; #2;
        push("async_ready", 0); push("async_busy", 0); push("async_nb_ready", 0);
        pop_chk("async_ready", 32'(ready));
        pop_chk("async_busy", 32'(rd_busy));
        pop_chk("async_nb_ready", 32'(nb_ready));

        step(); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0; #2;
        push("midinit_ready", 0); pop_chk("midinit_ready", 32'(ready));
        step(); rst_n = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            push("reinit_ready", (k == 32) ? 32'd1 : 32'd0);
            pop_chk("reinit_ready", 32'(ready));
        end
        #2;
        push("reinit_busy", 0); push("reinit_x9", 0);
        pop_chk("reinit_busy", 32'(rd_busy));
        pop_chk("reinit_x9", rd_data[0]);
        step(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd3; #2;
        push("reinit_x5", 0); push("reinit_x3", 0);
        pop_chk("reinit_x5", rd_data[0]);
        pop_chk("reinit_x3", rd_data[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
